// File: rtl/jtag_pkg.sv
// Shared constants and state encoding for the host-side JTAG shift engine.
package jtag_pkg;

    localparam int         NUM_CHAINS = 12;
    localparam logic [3:0] SEL_NONE   = 4'hF;
    localparam logic       TMS_IDLE   = 1'b1;
    localparam logic       TDI_IDLE   = 1'b0;

    typedef enum logic [1:0] {
        IDLE,
        LOW,
        HIGH,
        RESP
    } state_t;

endpackage

// File: rtl/jtag_tck_gen.sv
// TCK half-period generator: down-counter reloaded from the latched divider,
// emitting rise/fall strobes on the cycle each half-period expires.
module jtag_tck_gen #(
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             en,
    input  logic [DIV_W-1:0] div,
    output logic             rise,
    output logic             fall,
    output logic             tck
);

    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] cnt;
    logic             expire;

    assign expire = en && (cnt == '0);
    assign rise   = expire && !tck;
    assign fall   = expire && tck;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            tck <= 1'b0;
        end else if (load) begin
            cnt <= div;
            tck <= 1'b0;
        end else if (expire) begin
            cnt <= div_q;
            tck <= ~tck;
        end else if (en) begin
            cnt <= cnt - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (load) begin
            div_q <= div;
        end
    end

endmodule

// File: rtl/jtag_shift_master.sv
// Host-side JTAG engine: shifts one TMS/TDI command LSB-first on a virtual TCK
// and returns the TDO captured at each rising edge through a valid/ready response.
module jtag_shift_master #(
    parameter int MAX_BITS = 32,
    parameter int LEN_W    = 5,
    parameter int DIV_W    = 8
) (
    input  logic                CLK,
    input  logic                RST_N,
    input  logic                CMD_VALID,
    output logic                CMD_READY,
    input  logic [MAX_BITS-1:0] CMD_TMS,
    input  logic [MAX_BITS-1:0] CMD_TDI,
    input  logic [LEN_W-1:0]    CMD_LEN_M1,
    input  logic [3:0]          CMD_SEL,
    input  logic [DIV_W-1:0]    CMD_DIV,
    output logic                RSP_VALID,
    input  logic                RSP_READY,
    output logic [MAX_BITS-1:0] RSP_TDO,
    output logic                BUSY,
    output logic [3:0]          JTAG_SEL,
    output logic                V_TCK,
    output logic                V_TMS,
    output logic                V_TDI,
    input  logic                V_TDO
);

    import jtag_pkg::*;

    state_t              state;
    state_t              state_n;
    logic                accept;
    logic                rsp_done;
    logic                shifting;
    logic                last_bit;
    logic                rise;
    logic                fall;
    logic [LEN_W-1:0]    bit_cnt;
    logic [LEN_W-1:0]    len_q;
    logic [MAX_BITS-1:0] tms_sr;
    logic [MAX_BITS-1:0] tdi_sr;

    assign accept   = CMD_VALID && CMD_READY;
    assign rsp_done = RSP_VALID && RSP_READY;
    assign shifting = (state == LOW) || (state == HIGH);
    assign last_bit = (bit_cnt == len_q);

    jtag_tck_gen #(
        .DIV_W (DIV_W)
    ) u_tck_gen (
        .clk   (CLK),
        .rst_n (RST_N),
        .load  (accept),
        .en    (shifting),
        .div   (CMD_DIV),
        .rise  (rise),
        .fall  (fall),
        .tck   (V_TCK)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:    if (accept)   state_n = LOW;
            LOW:     if (rise)     state_n = HIGH;
            HIGH:    if (fall)     state_n = last_bit ? RESP : LOW;
            RESP:    if (rsp_done) state_n = IDLE;
            default:               state_n = IDLE;
        endcase
    end

    // Handshake flags, pin drivers, bit counter and captured TDO.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            CMD_READY <= 1'b1;
            BUSY      <= 1'b0;
            RSP_VALID <= 1'b0;
            RSP_TDO   <= '0;
            JTAG_SEL  <= SEL_NONE;
            V_TMS     <= TMS_IDLE;
            V_TDI     <= TDI_IDLE;
            bit_cnt   <= '0;
        end else begin
            if (accept) begin
                CMD_READY <= 1'b0;
                BUSY      <= 1'b1;
                RSP_TDO   <= '0;
                JTAG_SEL  <= CMD_SEL;
                V_TMS     <= CMD_TMS[0];
                V_TDI     <= CMD_TDI[0];
                bit_cnt   <= '0;
            end
            if (rise) begin
                RSP_TDO[bit_cnt] <= V_TDO;
            end
            if (fall) begin
                if (last_bit) begin
                    RSP_VALID <= 1'b1;
                end else begin
                    bit_cnt <= bit_cnt + 1'b1;
                    V_TMS   <= tms_sr[0];
                    V_TDI   <= tdi_sr[0];
                end
            end
            if (rsp_done) begin
                RSP_VALID <= 1'b0;
                BUSY      <= 1'b0;
                CMD_READY <= 1'b1;
            end
        end
    end

    // Bit 0 goes straight to the pins on accept, so the shifters hold bits 1..N-1.
    always_ff @(posedge CLK) begin
        if (accept) begin
            len_q  <= CMD_LEN_M1;
            tms_sr <= CMD_TMS >> 1;
            tdi_sr <= CMD_TDI >> 1;
        end else if (fall && !last_bit) begin
            tms_sr <= tms_sr >> 1;
            tdi_sr <= tdi_sr >> 1;
        end
    end

endmodule

// File: tb/tb_jtag_shift_master.sv
// Directed and randomized bench for jtag_shift_master with a pin-level chain/TAP model.
module tb_jtag_shift_master;

    import jtag_pkg::*;

    localparam int MAX_BITS = 32;
    localparam int LEN_W    = 5;
    localparam int DIV_W    = 8;

    logic                CLK        = 1'b0;
    logic                RST_N      = 1'b0;
    logic                CMD_VALID  = 1'b0;
    logic                CMD_READY;
    logic [MAX_BITS-1:0] CMD_TMS    = '0;
    logic [MAX_BITS-1:0] CMD_TDI    = '0;
    logic [LEN_W-1:0]    CMD_LEN_M1 = '0;
    logic [3:0]          CMD_SEL    = '0;
    logic [DIV_W-1:0]    CMD_DIV    = '0;
    logic                RSP_VALID;
    logic                RSP_READY  = 1'b0;
    logic [MAX_BITS-1:0] RSP_TDO;
    logic                BUSY;
    logic [3:0]          JTAG_SEL;
    logic                V_TCK;
    logic                V_TMS;
    logic                V_TDI;
    logic                V_TDO;

    int vectors     = 0;
    int miscompares = 0;

    // Chain model state, owned by the monitor process.
    logic [31:0] next_tdo  = '0;
    logic [31:0] cur_tdo   = '0;
    logic [31:0] obs_tms   = '0;
    logic [31:0] obs_tdi   = '0;
    int          rise_cnt  = 0;
    int          run_len   = 0;
    int          width_err = 0;
    int          sel_err   = 0;
    int          mon_div   = 0;
    logic [3:0]  mon_sel   = SEL_NONE;
    logic [3:0]  prev_sel  = SEL_NONE;
    logic        prev_tck  = 1'b0;

    jtag_shift_master #(
        .MAX_BITS (MAX_BITS),
        .LEN_W    (LEN_W),
        .DIV_W    (DIV_W)
    ) dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .CMD_VALID  (CMD_VALID),
        .CMD_READY  (CMD_READY),
        .CMD_TMS    (CMD_TMS),
        .CMD_TDI    (CMD_TDI),
        .CMD_LEN_M1 (CMD_LEN_M1),
        .CMD_SEL    (CMD_SEL),
        .CMD_DIV    (CMD_DIV),
        .RSP_VALID  (RSP_VALID),
        .RSP_READY  (RSP_READY),
        .RSP_TDO    (RSP_TDO),
        .BUSY       (BUSY),
        .JTAG_SEL   (JTAG_SEL),
        .V_TCK      (V_TCK),
        .V_TMS      (V_TMS),
        .V_TDI      (V_TDI),
        .V_TDO      (V_TDO)
    );

    always #5 CLK = ~CLK;

    // Existing chains return their TDO bit for the upcoming rising edge; others read 0.
    assign V_TDO = (int'(JTAG_SEL) < NUM_CHAINS && rise_cnt < MAX_BITS) ? cur_tdo[rise_cnt[4:0]] : 1'b0;

    always @(negedge CLK) begin
        #1;
        if (RST_N && CMD_VALID && CMD_READY) begin
            rise_cnt  = 0;
            obs_tms   = '0;
            obs_tdi   = '0;
            width_err = 0;
            sel_err   = 0;
            run_len   = 0;
            mon_div   = int'(CMD_DIV);
            mon_sel   = CMD_SEL;
            cur_tdo   = next_tdo;
        end else if (V_TCK && !prev_tck) begin
            if (rise_cnt > 0 && run_len != mon_div + 1) width_err++;
            if (rise_cnt < MAX_BITS) begin
                obs_tms[rise_cnt[4:0]] = V_TMS;
                obs_tdi[rise_cnt[4:0]] = V_TDI;
            end
            if (JTAG_SEL !== mon_sel) sel_err++;
            rise_cnt++;
            run_len = 1;
        end else if (!V_TCK && prev_tck) begin
            if (run_len != mon_div + 1) width_err++;
            run_len = 1;
        end else begin
            run_len++;
        end
        if (JTAG_SEL !== prev_sel && (V_TCK || prev_tck)) sel_err++;
        prev_tck = V_TCK;
        prev_sel = JTAG_SEL;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_vals();
        check("rst_tck",       32'(V_TCK),     32'd0);
        check("rst_tms",       32'(V_TMS),     32'd1);
        check("rst_tdi",       32'(V_TDI),     32'd0);
        check("rst_sel",       32'(JTAG_SEL),  32'hF);
        check("rst_cmd_ready", 32'(CMD_READY), 32'd1);
        check("rst_rsp_valid", 32'(RSP_VALID), 32'd0);
        check("rst_rsp_tdo",   RSP_TDO,        32'd0);
        check("rst_busy",      32'(BUSY),      32'd0);
    endtask

    task automatic present(input logic [31:0] tms, input logic [31:0] tdi, input int len_m1,
                           input int sel, input int div, input logic [31:0] tdo);
        @(negedge CLK);
        CMD_TMS    = tms;
        CMD_TDI    = tdi;
        CMD_LEN_M1 = LEN_W'(len_m1);
        CMD_SEL    = 4'(sel);
        CMD_DIV    = DIV_W'(div);
        next_tdo   = tdo;
        CMD_VALID  = 1'b1;
    endtask

    task automatic wait_accept();
        int guard = 0;
        while (CMD_READY !== 1'b1 && guard < 1000) begin
            @(negedge CLK);
            guard++;
        end
        check("accept_ready", 32'(CMD_READY), 32'd1);
        @(posedge CLK);
    endtask

    task automatic scramble();
        CMD_VALID  = 1'b0;
        CMD_TMS    = $urandom;
        CMD_TDI    = $urandom;
        CMD_LEN_M1 = LEN_W'($urandom);
        CMD_SEL    = 4'($urandom);
        CMD_DIV    = DIV_W'($urandom);
    endtask

    // Entered on the negedge following the accept edge; counts edges from accept.
    task automatic wait_rsp(output int lat);
        lat = 1;
        while (RSP_VALID !== 1'b1 && lat < 20000) begin
            @(posedge CLK);
            lat++;
            @(negedge CLK);
        end
        #2;
    endtask

    task automatic check_rsp(input logic [31:0] tms, input logic [31:0] tdi, input int len_m1,
                             input int sel, input int div, input logic [31:0] tdo, input int lat);
        int          n       = len_m1 + 1;
        logic [31:0] mask    = (n >= 32) ? 32'hFFFF_FFFF : ((32'd1 << n) - 32'd1);
        logic [31:0] exp_tdo = (sel < NUM_CHAINS) ? (tdo & mask) : 32'd0;
        check("latency",    lat,             1 + 2 * n * (div + 1));
        check("rsp_valid",  32'(RSP_VALID),  32'd1);
        check("rsp_tdo",    RSP_TDO,         exp_tdo);
        check("busy",       32'(BUSY),       32'd1);
        check("cmd_ready",  32'(CMD_READY),  32'd0);
        check("tck_idle",   32'(V_TCK),      32'd0);
        check("jtag_sel",   32'(JTAG_SEL),   sel);
        check("tck_pulses", rise_cnt,        n);
        check("tms_seq",    obs_tms,         tms & mask);
        check("tdi_seq",    obs_tdi,         tdi & mask);
        check("tms_hold",   32'(V_TMS),      32'(tms[n-1]));
        check("tck_width",  width_err,       0);
        check("sel_glitch", sel_err,         0);
    endtask

    task automatic handshake();
        @(negedge CLK);
        RSP_READY = 1'b1;
        @(negedge CLK);
        RSP_READY = 1'b0;
        check("hs_rsp_valid", 32'(RSP_VALID), 32'd0);
        check("hs_busy",      32'(BUSY),      32'd0);
        check("hs_cmd_ready", 32'(CMD_READY), 32'd1);
    endtask

    task automatic run_cmd(input logic [31:0] tms, input logic [31:0] tdi, input int len_m1,
                           input int sel, input int div, input logic [31:0] tdo);
        int lat;
        present(tms, tdi, len_m1, sel, div, tdo);
        wait_accept();
        @(negedge CLK);
        scramble();
        wait_rsp(lat);
        check_rsp(tms, tdi, len_m1, sel, div, tdo, lat);
        handshake();
    endtask

    initial begin
        logic [31:0] a_tms, a_tdi, a_tdo, b_tms, b_tdi, b_tdo, exp_a;
        int          lat, guard;

        repeat (3) @(negedge CLK);
        check_reset_vals();
        RST_N = 1'b1;
        @(negedge CLK);
        check("idle_ready", 32'(CMD_READY), 32'd1);
        check("idle_sel",   32'(JTAG_SEL),  32'hF);

        // Single bit, fastest divider.
        run_cmd(32'h1, 32'h1, 0, 5, 0, 32'hFFFF_FFFF);

        // 8-bit IR shift on chain 3.
        run_cmd(32'h80, 32'hA5, 7, 3, 1, 32'h3C);

        // Backpressure: response held for 20 cycles while a new command is offered.
        a_tms = $urandom; a_tdi = $urandom; a_tdo = $urandom;
        present(a_tms, a_tdi, 11, 7, 2, a_tdo);
        wait_accept();
        @(negedge CLK);
        scramble();
        wait_rsp(lat);
        check_rsp(a_tms, a_tdi, 11, 7, 2, a_tdo, lat);
        exp_a = a_tdo & 32'hFFF;
        b_tms = $urandom; b_tdi = $urandom; b_tdo = $urandom;
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            if (i == 0) begin
                CMD_TMS = b_tms; CMD_TDI = b_tdi; CMD_LEN_M1 = LEN_W'(4);
                CMD_SEL = 4'd9;  CMD_DIV = DIV_W'(0); next_tdo = b_tdo;
                CMD_VALID = 1'b1;
            end
            check("bp_rsp_valid", 32'(RSP_VALID), 32'd1);
            check("bp_rsp_tdo",   RSP_TDO,        exp_a);
            check("bp_cmd_ready", 32'(CMD_READY), 32'd0);
            check("bp_tck",       32'(V_TCK),     32'd0);
        end
        @(negedge CLK);
        RSP_READY = 1'b1;
        check("bp_hs_cycle_ready", 32'(CMD_READY), 32'd0);
        @(negedge CLK);
        RSP_READY = 1'b0;
        check("bp_after_hs_valid", 32'(RSP_VALID), 32'd0);
        check("bp_after_hs_ready", 32'(CMD_READY), 32'd1);
        check("bp_after_hs_busy",  32'(BUSY),      32'd0);
        @(negedge CLK);
        check("bp_accept_ready", 32'(CMD_READY), 32'd0);
        check("bp_accept_busy",  32'(BUSY),      32'd1);
        check("bp_accept_sel",   32'(JTAG_SEL),  32'd9);
        scramble();
        wait_rsp(lat);
        check_rsp(b_tms, b_tdi, 4, 9, 0, b_tdo, lat);
        handshake();

        // Chain select beyond the populated range.
        run_cmd($urandom, $urandom, 31, 12, 0, 32'hFFFF_FFFF);

        // Reset in the middle of a 32-bit shift.
        a_tms = $urandom; a_tdi = $urandom; a_tdo = $urandom;
        present(a_tms, a_tdi, 31, 2, 3, a_tdo);
        wait_accept();
        @(negedge CLK);
        scramble();
        guard = 0;
        while (rise_cnt < 10 && guard < 2000) begin
            @(negedge CLK);
            guard++;
        end
        check("mid_shift_reached", 32'(rise_cnt >= 10), 32'd1);
        RST_N = 1'b0;
        #1;
        check_reset_vals();
        @(negedge CLK);
        RST_N = 1'b1;
        run_cmd(a_tms, a_tdi, 31, 2, 3, a_tdo);

        // Back-to-back with CMD_VALID and RSP_READY held high.
        a_tms = $urandom; a_tdi = $urandom; a_tdo = $urandom;
        b_tms = $urandom; b_tdi = $urandom; b_tdo = $urandom;
        RSP_READY = 1'b1;
        present(a_tms, a_tdi, 5, 0, 1, a_tdo);
        wait_accept();
        @(negedge CLK);
        CMD_TMS = b_tms; CMD_TDI = b_tdi; CMD_LEN_M1 = LEN_W'(6);
        CMD_SEL = 4'd11; CMD_DIV = DIV_W'(0); next_tdo = b_tdo;
        wait_rsp(lat);
        check_rsp(a_tms, a_tdi, 5, 0, 1, a_tdo, lat);
        @(negedge CLK);
        check("b2b_hs_valid", 32'(RSP_VALID), 32'd0);
        check("b2b_hs_ready", 32'(CMD_READY), 32'd1);
        check("b2b_hs_sel",   32'(JTAG_SEL),  32'd0);
        @(negedge CLK);
        check("b2b_acc_ready", 32'(CMD_READY), 32'd0);
        check("b2b_acc_sel",   32'(JTAG_SEL),  32'd11);
        check("b2b_acc_tck",   32'(V_TCK),     32'd0);
        scramble();
        wait_rsp(lat);
        check_rsp(b_tms, b_tdi, 6, 11, 0, b_tdo, lat);
        @(negedge CLK);
        check("b2b_auto_hs_valid", 32'(RSP_VALID), 32'd0);
        check("b2b_auto_hs_ready", 32'(CMD_READY), 32'd1);
        RSP_READY = 1'b0;

        // Randomized commands.
        for (int k = 0; k < 8; k++) begin
            run_cmd($urandom, $urandom, int'($urandom_range(31, 0)), int'($urandom_range(13, 0)),
                    int'($urandom_range(3, 0)), $urandom);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/jtag_shift_master.md
Name: jtag_shift_master

Overview:
- Host-side JTAG engine that generates the virtual TCK/TMS/TDI stream and captures TDO for the board's 12-chain JTAG fan-out mux.
- Accepts one shift command of up to MAX_BITS bits: TMS vector, TDI vector, length, chain select and TCK divider. Drives the bits LSB-first and returns the captured TDO vector through a valid/ready response.
- Sits between the host command interface and the chain mux: V_TCK, V_TMS, V_TDI and JTAG_SEL feed the mux; V_TDO comes back from it.

Parameters:
- MAX_BITS, 32, maximum bits per command (vector width).
- LEN_W, 5, width of CMD_LEN_M1; must be ≥ clog2(MAX_BITS).
- DIV_W, 8, width of CMD_DIV.

Ports:
- CLK  in  1  system clock.
- RST_N  in  1  asynchronous, active-low reset.
- CMD_VALID  in  1  command offered.
- CMD_READY  out  1  engine can accept a command.
- CMD_TMS  in  MAX_BITS  TMS value per bit, bit 0 first.
- CMD_TDI  in  MAX_BITS  TDI value per bit, bit 0 first.
- CMD_LEN_M1  in  LEN_W  bit count minus 1 (0 → 1 bit, 31 → 32 bits).
- CMD_SEL  in  4  chain select for this command.
- CMD_DIV  in  DIV_W  TCK half-period = CMD_DIV+1 CLK cycles.
- RSP_VALID  out  1  captured TDO available.
- RSP_READY  in  1  host accepts response.
- RSP_TDO  out  MAX_BITS  captured TDO; bit i = TDO sampled at rising TCK of bit i; bits ≥ N are 0.
- BUSY  out  1  high from command accept until response handshake completes.
- JTAG_SEL  out  4  chain select to the mux.
- V_TCK  out  1  generated TCK.
- V_TMS  out  1  generated TMS.
- V_TDI  out  1  generated TDI.
- V_TDO  in  1  selected chain TDO from the mux.

Behaviour:
- All outputs are registered. Reset values: V_TCK=0, V_TMS=1, V_TDI=0, JTAG_SEL=4'hF (no chain), CMD_READY=1, RSP_VALID=0, RSP_TDO=0, BUSY=0.
- States:
  - IDLE → LOW on CMD_VALID&&CMD_READY.
  - LOW → HIGH when the half-period counter expires.
  - HIGH → LOW when the counter expires and bits remain.
  - HIGH → RESP when the counter expires and the last bit is done.
  - RESP → IDLE on RSP_READY.
- CMD_READY=1 only in IDLE. All CMD_* inputs are latched on accept; later input changes are ignored.
- Cycle after accept (entering LOW):
  - JTAG_SEL=CMD_SEL, V_TMS=CMD_TMS[0], V_TDI=CMD_TDI[0], V_TCK=0.
  - Half-period counter loaded with CMD_DIV.
- LOW held CMD_DIV+1 cycles. On the LOW→HIGH edge: V_TCK←1 and V_TDO is registered into RSP_TDO[bit].
- HIGH held CMD_DIV+1 cycles. On the HIGH→LOW edge: V_TCK←0, and V_TMS/V_TDI advance to the next bit on the same edge.
- On entering RESP: V_TCK←0, RSP_VALID←1. V_TMS/V_TDI/JTAG_SEL hold their last values. RSP_TDO is stable while RSP_VALID=1.
- Latency, accept to RSP_VALID: 1 + N·2·(CMD_DIV+1) cycles, N = CMD_LEN_M1+1.
- RSP_VALID&&RSP_READY: RSP_VALID←0, BUSY←0, CMD_READY←1 next cycle. JTAG_SEL keeps its last value until the next command.
- RSP_READY held high before completion: handshake occurs on the first RESP cycle.
- CMD_VALID in the same cycle as the response handshake: not accepted; CMD_READY rises the following cycle.
- CMD_SEL ≥ 12 is passed through unchanged. The mux returns TDO=0, so RSP_TDO is all zeros; no error is flagged.
- RSP_TDO is cleared to 0 on command accept.
- RST_N low at any time, including mid-shift: all outputs take their reset values immediately and the command is discarded. Shifting resumes only after a new accept.
- Bit counter and divider counter are sized exactly to LEN_W and DIV_W; no wrap beyond CMD_LEN_M1.

Decomposition:
- Package jtag_pkg:
  - NUM_CHAINS=12.
  - SEL_NONE=4'hF.
  - Reset levels TMS_IDLE=1, TDI_IDLE=0.
  - State enum {IDLE, LOW, HIGH, RESP}.
- Sub-module jtag_tck_gen: half-period down-counter. Inputs load/div; outputs rise/fall strobes and the V_TCK register. The top level keeps the FSM, shift registers and handshakes.

Test Plan:
- Reset mid-shift: N=32, DIV=3, assert RST_N=0 at bit 10 → V_TCK=0, V_TMS=1, JTAG_SEL=4'hF immediately. The next command runs cleanly from bit 0.
- Single bit: N=1 (LEN_M1=0), DIV=0, TMS=1, TDI=1, V_TDO=1 → one TCK pulse, 1 cycle high. RSP_VALID 3 cycles after accept, RSP_TDO=32'h1.
- 8-bit IR shift: LEN_M1=7, DIV=1, TDI=8'hA5, TMS=8'h80, SEL=3, TAP model returns 8'h3C → eight TCK pulses, each 2 high / 2 low. TDI observed LSB-first at rising edges; TMS=1 only on bit 7. JTAG_SEL=3, RSP_TDO=32'h3C, latency 33 cycles.
- Backpressure: RSP_READY=0 for 20 cycles after completion → RSP_VALID/RSP_TDO stable, CMD_READY=0, V_TCK=0. A new CMD_VALID is ignored until the handshake plus 1 cycle.
- Unselected chain: SEL=12, 32 bits, DIV=0, mux model → RSP_TDO=0 and JTAG_SEL=12 throughout the shift.
- Back-to-back: two commands with SEL 0 then 11, CMD_VALID held high → second accepted exactly 1 cycle after the first response handshake. JTAG_SEL switches 0→11 on that accept edge; no TCK edge while it changes.
